// File: rtl/cfg_frame_loader.sv
// Column configuration frame loader: decodes header/data packets from a word
// stream and drives registered FrameData plus a single-cycle FrameStrobe per word.
module cfg_frame_loader #(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter logic [4:0] ColAddr         = 5'd0
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Done,
  output logic                       Error
);

  typedef enum logic [1:0] {
    Hdr,
    Data,
    Setup,
    Strobe
  } stateT;

  stateT                      state;
  stateT                      nextState;
  logic                       colMatch;
  logic [4:0]                 frameIdx;
  logic [15:0]                remaining;
  logic                       wordXfer;
  logic                       inRange;
  logic [MaxFramesPerCol-1:0] oneHot;

  assign WordReady = !reset && ((state == Hdr) || (state == Data));
  assign wordXfer  = WordValid && WordReady;
  assign inRange   = (int'(frameIdx) < MaxFramesPerCol);

  always_comb begin
    oneHot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      oneHot[i] = (int'(frameIdx) == i);
    end
  end

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (reset) state <= Hdr;
    else       state <= nextState;
  end

  // NOTE: nextState is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      Hdr:    if (wordXfer && (WordData[15:0] != 16'd0)) nextState = Data;
      Data:   if (wordXfer) nextState = Setup;
      Setup:  nextState = Strobe;
      Strobe: nextState = (remaining == 16'd1) ? Hdr : Data;
      default: nextState = Hdr;
    endcase
  end

  // Packet context and column-facing outputs; a zero-length header is dropped
  // without touching any state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      colMatch    <= 1'b0;
      frameIdx    <= '0;
      remaining   <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      Done        <= 1'b0;
      Error       <= 1'b0;
    end else begin
      FrameStrobe <= '0;
      Done        <= 1'b0;
      case (state)
        Hdr: begin
          if (wordXfer && (WordData[15:0] != 16'd0)) begin
            colMatch  <= (WordData[31:27] == ColAddr);
            frameIdx  <= WordData[20:16];
            remaining <= WordData[15:0];
          end
        end
        Data: begin
          // Words of a foreign column are consumed but never reach the latches.
          if (wordXfer && colMatch) FrameData <= WordData;
        end
        Setup: begin
          if (colMatch && inRange) FrameStrobe <= oneHot;
        end
        Strobe: begin
          if (colMatch && !inRange) Error <= 1'b1;
          frameIdx  <= frameIdx + 5'd1;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
